// File: rtl/trig_tag_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cdt_tag_pkg: shared constants, record field map, FSM type. Rev 1.0 |
// +--------------------------------------------------------------------+
package cdt_tag_pkg;

  localparam logic [15:0] TAG_HEADER = 16'hEEEE;
  localparam int          TAG_WORDS  = 9;
  localparam int          ID_W       = 10;
  localparam int          REC_W      = 128;
  localparam int          WORD_W     = 16;

  // Word index k places data word k at rec[16k-1 -: 16]
  localparam int W_EVENT_ID = 1;
  localparam int W_VETO_LO  = 2;
  localparam int W_VETO_HI  = 3;
  localparam int W_TS_LO    = 4;
  localparam int W_TS_HI    = 5;
  localparam int W_TRIG     = 6;
  localparam int W_CLUS     = 7;
  localparam int W_ET_RAW   = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  function automatic int word_lsb(input int k);
    return WORD_W * (k - 1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c, input logic clr,
                                            input logic inc);
    logic [15:0] b;
    b = clr ? 16'd0 : c;
    return (inc && (b != 16'hFFFF)) ? b + 16'd1 : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tag_fifo: synchronous FWFT FIFO with flush; dout is 0 when empty.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tag_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A pop frees the slot a same-cycle push needs, so push-while-full is legal with pop
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/trig_tag_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | trig_tag_buffer: trigger-tag frame reassembly, checks, FWFT buffer. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module trig_tag_buffer
  import cdt_tag_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_live,
  input  logic                      in_early_lv1,
  input  logic [15:0]               in_trig_tag,
  input  logic                      rd_en,
  output logic [127:0]              rd_data,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      lv2_full,
  output logic [19:0]               frame_cnt,
  output logic [15:0]               abort_cnt,
  output logic [15:0]               hdr_err_cnt,
  output logic [15:0]               id_err_cnt,
  output logic [15:0]               ovf_cnt
);

  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL_TH   = CW'(DEPTH - FULL_MARGIN);
  localparam logic [2:0]     LAST_SLOT = 3'(TAG_WORDS - 2);

  state_t            state;
  logic [2:0]        slot;
  logic [REC_W-1:0]  rec;
  logic              live_d;
  logic              exp_valid;
  logic [ID_W-1:0]   exp_id;

  logic              full;
  logic              hdr_ok;
  logic              strobe;
  logic              push_req;
  logic              push_ok;
  logic              pop_ok;
  logic              drop;
  logic              id_bad;
  logic              clr;
  logic [REC_W-1:0]  push_rec;
  logic [ID_W-1:0]   new_id;
  logic [CW-1:0]     occ_next;
  logic [19:0]       frame_base;

  assign hdr_ok   = (in_trig_tag == TAG_HEADER);
  assign strobe   = in_live && in_early_lv1;
  assign push_req = in_live && (state == BODY) && !in_early_lv1 && (slot == LAST_SLOT);
  assign push_rec = {in_trig_tag, rec[REC_W-WORD_W-1:0]};
  assign pop_ok   = in_live && rd_en && !empty;
  assign push_ok  = push_req && (!full || pop_ok);
  assign drop     = push_req && !push_ok;
  assign new_id   = push_rec[word_lsb(W_EVENT_ID) +: ID_W];
  assign id_bad   = push_ok && exp_valid && (new_id != exp_id);
  assign clr      = in_live && !live_d;
  assign occ_next = occupancy + CW'(push_ok) - CW'(pop_ok);

  // slot holds (word index - 1) of the next body word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      slot      <= '0;
      rec       <= '0;
      exp_valid <= 1'b0;
      exp_id    <= '0;
    end else if (!in_live) begin
      state     <= IDLE;
      slot      <= '0;
      exp_valid <= 1'b0;
    end else begin
      if (in_early_lv1) begin
        slot  <= '0;
        state <= hdr_ok ? BODY : IDLE;
      end else if (state == BODY) begin
        rec[{slot, 4'b0000} +: WORD_W] <= in_trig_tag;
        if (slot == LAST_SLOT) state <= IDLE;
        else                   slot  <= slot + 3'd1;
      end
      if (push_ok) begin
        exp_valid <= 1'b1;
        exp_id    <= new_id + ID_W'(1);
      end
    end
  end

  assign frame_base = clr ? 20'd0 : frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_d      <= 1'b0;
      lv2_full    <= 1'b0;
      frame_cnt   <= '0;
      abort_cnt   <= '0;
      hdr_err_cnt <= '0;
      id_err_cnt  <= '0;
      ovf_cnt     <= '0;
    end else begin
      live_d   <= in_live;
      lv2_full <= in_live && (occ_next >= FULL_TH);
      if (in_live) begin
        frame_cnt   <= (push_ok && frame_base != 20'hFFFFF) ? frame_base + 20'd1 : frame_base;
        abort_cnt   <= sat_inc16(abort_cnt, clr, strobe && (state == BODY));
        hdr_err_cnt <= sat_inc16(hdr_err_cnt, clr, strobe && !hdr_ok);
        id_err_cnt  <= sat_inc16(id_err_cnt, clr, id_bad);
        ovf_cnt     <= sat_inc16(ovf_cnt, clr, drop);
      end
    end
  end

  tag_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (!in_live),
    .push  (push_ok),
    .pop   (pop_ok),
    .din   (push_rec),
    .dout  (rd_data),
    .empty (empty),
    .full  (full),
    .count (occupancy)
  );

endmodule
`default_nettype wire
